// File: rtl/pipe_pkg.sv
// Purpose: shared pipeline-control types and constants (FSM states, register zero, stage enable encoding).
// Latency: n/a (declarations only).
// Backpressure: n/a; HOLD/ADVANCE encode the per-stage stall polarity used by every pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Stage enable encoding: 0 = stage captures, 1 = stage holds.
    localparam logic ADVANCE = 1'b0;
    localparam logic HOLD    = 1'b1;

endpackage

// File: rtl/load_use_detect.sv
// Purpose: flags a load in EX whose destination is a source of the instruction in ID.
// Latency: purely combinational, same cycle.
// Backpressure: none; the controller decides whether the hazard is acted on.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rt,
    input  logic       ex_mem_rd,
    output logic       lu_hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rt);
    assign rt_match = id_uses_rt && (id_rt == ex_rt);

    // Register zero is never a real dependency, so a load into it cannot stall.
    assign lu_hazard = ex_mem_rd && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: drives PC/stage enables plus bubble and IF/ID flush strobes for the five-stage pipe.
// Latency: outputs combinational from registered state and current inputs; state updates on posedge.
// Backpressure: a pending data-memory access freezes all stages until mem_ready or timeout.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_rd,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        pc_enable,
    output logic        IF_ID_enable,
    output logic        ID_EX_enable,
    output logic        EX_MEM_enable,
    output logic        MEM_WB_enable,
    output logic        ctrl_bubble,
    output logic        IF_ID_flush,
    output logic        mem_err,
    output logic [31:0] stall_count
);

    localparam logic [2:0] FLUSH_INIT = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic        br_pend_q, br_pend_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic lu_hazard;
    logic timeout;
    logic freeze;
    logic br_eff;
    logic flushing;
    logic stall_now;

    load_use_detect u_load_use_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_rt      (ex_rt),
        .ex_mem_rd  (ex_mem_rd),
        .lu_hazard  (lu_hazard)
    );

    // Once the wait counter has hit the limit the access is abandoned and the pipe released.
    assign timeout  = (state_q == MEM_WAIT) && (wcnt_q == WAIT_LIMIT);
    assign freeze   = mem_req && !mem_ready && !timeout;
    // A branch deferred by a memory wait behaves exactly like a fresh one on release.
    assign br_eff   = branch_taken || br_pend_q;
    // fcnt is nonzero only while flush cycles remain, which also survives a freeze mid-flush.
    assign flushing = br_eff || (fcnt_q != 3'd0);
    // PC holds on a freeze or on a load-use stall; reset is excluded as the counter is cleared then.
    assign stall_now = freeze || (!flushing && lu_hazard);

    // Stage enables and strobes, in priority order: reset, memory wait, branch flush, load-use.
    always_comb begin
        pc_enable     = ADVANCE;
        IF_ID_enable  = ADVANCE;
        ID_EX_enable  = ADVANCE;
        EX_MEM_enable = ADVANCE;
        MEM_WB_enable = ADVANCE;
        ctrl_bubble   = 1'b0;
        IF_ID_flush   = 1'b0;
        if (rst) begin
            pc_enable     = HOLD;
            IF_ID_enable  = HOLD;
            ID_EX_enable  = HOLD;
            EX_MEM_enable = HOLD;
            MEM_WB_enable = HOLD;
            ctrl_bubble   = 1'b1;
            IF_ID_flush   = 1'b1;
        end else if (freeze) begin
            pc_enable     = HOLD;
            IF_ID_enable  = HOLD;
            ID_EX_enable  = HOLD;
            EX_MEM_enable = HOLD;
            MEM_WB_enable = HOLD;
        end else if (flushing) begin
            ctrl_bubble   = 1'b1;
            IF_ID_flush   = 1'b1;
        end else if (lu_hazard) begin
            pc_enable     = HOLD;
            IF_ID_enable  = HOLD;
            ctrl_bubble   = 1'b1;
        end
    end

    // The error is visible in the very cycle the timeout releases the pipe, then held by the register.
    assign mem_err     = !rst && (mem_err_q || timeout);
    assign stall_count = stall_count_q;

    // Next-state logic for the FSM, pending branch, counters and sticky error.
    always_comb begin
        state_d       = state_q;
        br_pend_d     = br_pend_q;
        fcnt_d        = fcnt_q;
        wcnt_d        = wcnt_q;
        mem_err_d     = mem_err_q || timeout;
        stall_count_d = stall_count_q;
        if (freeze) begin
            state_d   = MEM_WAIT;
            wcnt_d    = wcnt_q + 8'd1;
            br_pend_d = br_pend_q || branch_taken;
        end else begin
            wcnt_d    = 8'd0;
            br_pend_d = 1'b0;
            if (br_eff) begin
                if (BRANCH_PENALTY > 1) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_INIT;
                end else begin
                    state_d = RUN;
                    fcnt_d  = 3'd0;
                end
            end else if (fcnt_q != 3'd0) begin
                fcnt_d  = fcnt_q - 3'd1;
                state_d = (fcnt_q == 3'd1) ? RUN : FLUSH;
            end else begin
                state_d = RUN;
            end
        end
        if (stall_now && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // State registers; reset drops any pending wait, flush or deferred branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            br_pend_q     <= 1'b0;
            fcnt_q        <= 3'd0;
            wcnt_q        <= 8'd0;
            mem_err_q     <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            br_pend_q     <= br_pend_d;
            fcnt_q        <= fcnt_d;
            wcnt_q        <= wcnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl using an expected-value queue per applied cycle.
// Latency: inputs driven 1ns after posedge, outputs sampled on the following negedge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_rd;
    logic        mem_req, mem_ready, branch_taken;
    logic        pc_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable;
    logic        ctrl_bubble, IF_ID_flush, mem_err;
    logic [31:0] stall_count;

    hazard_ctrl #(
        .BRANCH_PENALTY (2),
        .MEM_TIMEOUT    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_rt         (ex_rt),
        .ex_mem_rd     (ex_mem_rd),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .branch_taken  (branch_taken),
        .pc_enable     (pc_enable),
        .IF_ID_enable  (IF_ID_enable),
        .ID_EX_enable  (ID_EX_enable),
        .EX_MEM_enable (EX_MEM_enable),
        .MEM_WB_enable (MEM_WB_enable),
        .ctrl_bubble   (ctrl_bubble),
        .IF_ID_flush   (IF_ID_flush),
        .mem_err       (mem_err),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    // Flag order: pc, IF_ID, ID_EX, EX_MEM, MEM_WB, bubble, flush, mem_err
    localparam logic [7:0] F_IDLE = 8'b0000_0000;
    localparam logic [7:0] F_RST  = 8'b1111_1110;
    localparam logic [7:0] F_FRZ  = 8'b1111_1000;
    localparam logic [7:0] F_LU   = 8'b1100_0100;
    localparam logic [7:0] F_FL   = 8'b0000_0110;
    localparam logic [7:0] F_ERR  = 8'b0000_0001;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ert;
        logic       urs;
        logic       urt;
        logic       mrd;
        logic       req;
        logic       rdy;
        logic       br;
        logic [7:0] flags;
    } row_t;

    logic [39:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int exp_cnt     = 0;

    function automatic row_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] ert, input logic urs, input logic urt,
                                input logic mrd, input logic req, input logic rdy,
                                input logic br, input logic [7:0] fl);
        row_t x;
        x.rst = r; x.rs = rs; x.rt = rt; x.ert = ert; x.urs = urs; x.urt = urt;
        x.mrd = mrd; x.req = req; x.rdy = rdy; x.br = br; x.flags = fl;
        return x;
    endfunction

    function automatic logic [39:0] observed();
        return {pc_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable, MEM_WB_enable,
                ctrl_bubble, IF_ID_flush, mem_err, stall_count};
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must be in that cycle.
    task automatic drive_and_expect(input row_t r);
        rst = r.rst; id_rs = r.rs; id_rt = r.rt; ex_rt = r.ert;
        id_uses_rs = r.urs; id_uses_rt = r.urt; ex_mem_rd = r.mrd;
        mem_req = r.req; mem_ready = r.rdy; branch_taken = r.br;
        exp_q.push_back({r.flags, r.rst ? 32'd0 : 32'(exp_cnt)});
        if (r.rst) exp_cnt = 0;
        else if (r.flags[7]) exp_cnt++;
    endtask

    task automatic test_reset();
        row_t r[$];
        logic [39:0] e, o;
        r.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST));
        r.push_back(mk(1, 8, 0, 8, 1, 0, 1, 1, 0, 1, F_RST));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        row_t r[$];
        logic [39:0] e, o;
        r.push_back(mk(0, 8, 0, 8, 1, 0, 1, 0, 0, 0, F_LU));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        r.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, F_IDLE));
        r.push_back(mk(0, 3, 5, 5, 1, 1, 1, 0, 0, 0, F_LU));
        r.push_back(mk(0, 3, 5, 5, 1, 0, 1, 0, 0, 0, F_IDLE));
        r.push_back(mk(0, 8, 0, 8, 1, 0, 0, 0, 0, 0, F_IDLE));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        row_t r[$];
        logic [39:0] e, o;
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, F_FL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_FL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        r.push_back(mk(0, 8, 0, 8, 1, 0, 1, 0, 0, 1, F_FL));
        r.push_back(mk(0, 8, 0, 8, 1, 0, 1, 0, 0, 0, F_FL));
        r.push_back(mk(0, 8, 0, 8, 1, 0, 1, 0, 0, 0, F_LU));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branch[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        row_t r[$];
        logic [39:0] e, o;
        r.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, F_IDLE));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mem_wait[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_during_wait();
        row_t r[$];
        logic [39:0] e, o;
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, F_FL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_FL));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branch_wait[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        row_t r[$];
        logic [39:0] e, o;
        for (int k = 0; k < 4; k++) r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_FRZ));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_ERR));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_ERR));
        r.push_back(mk(0, 8, 0, 8, 1, 0, 1, 0, 0, 0, F_LU | F_ERR));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_ERR));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_flush();
        row_t r[$];
        logic [39:0] e, o;
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, F_FL | F_ERR));
        r.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_RST));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_IDLE));
        foreach (r[i]) begin
            drive_and_expect(r[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observed();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid_flush[%0d]: got flags=%b count=%0d, want flags=%b count=%0d",
                         i, o[39:32], o[31:0], e[39:32], e[31:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_rd = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_branch_during_wait();
        test_timeout();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It generates the `IF_ID`, `ID_EX`, `EX_MEM` and `MEM_WB` stage enables, the PC enable, and the bubble and flush strobes. It is the driving end of the per-stage `*_enable` interface that the pipeline registers consume. It resolves three hazards: load-use data hazards, taken-branch flushes, and multi-cycle data-memory waits.

## Interface
- `BRANCH_PENALTY`, 2: cycles of IF/ID flush per taken branch (1..7).
- `MEM_TIMEOUT`, 255: maximum wait cycles for `mem_ready` before `mem_err` (1..255).
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction reads rs / rt.
- `ex_rt` in 5: `rt_out` of `ID_EX`, the load destination.
- `ex_mem_rd` in 1: `flag_mem_rd_out` of `ID_EX`.
- `mem_req` in 1: `EX_MEM` holds a load or store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `branch_taken` in 1: EX resolves a taken branch/jump this cycle.
- `pc_enable`, `IF_ID_enable`, `ID_EX_enable`, `EX_MEM_enable`, `MEM_WB_enable` out 1 each: 0 = stage captures, 1 = stage holds.
- `ctrl_bubble` out 1: zero `flag_mem_rd`, `flag_mem_wr` and `flag_banco_wr` entering `ID_EX`.
- `IF_ID_flush` out 1: `IF_ID` loads a NOP.
- `mem_err` out 1: sticky memory-timeout flag.
- `stall_count` out 32: saturating count of cycles with `pc_enable`=1.

## Operation
- **States:** RUN, MEM_WAIT, FLUSH. Pending-branch bit `br_pend`. 3-bit flush counter `fcnt`. 8-bit wait counter `wcnt`.
- **Priority, highest first:** memory wait, branch flush, load-use.
- **Memory wait:** `mem_req`=1 and `mem_ready`=0, in any state.
  - All five enables = 1; the whole pipe freezes.
  - Next state MEM_WAIT; `wcnt` increments.
  - Exit the cycle `mem_ready`=1; that cycle the enables follow normal rules.
  - When `wcnt` reaches `MEM_TIMEOUT`, set `mem_err`, force exit to RUN and release the pipe.
- **Branch:** `branch_taken`=1 outside MEM_WAIT.
  - `IF_ID_flush`=1 and `ctrl_bubble`=1 that cycle.
  - If `BRANCH_PENALTY`>1, enter FLUSH with `fcnt`=`BRANCH_PENALTY`-1. FLUSH keeps both strobes at 1 and decrements `fcnt`, returning to RUN at 0.
  - `branch_taken` during MEM_WAIT sets `br_pend`. The flush is applied in the first cycle after MEM_WAIT exits, then `br_pend` clears.
- **Load-use:** in RUN, with no branch and no memory wait.
  - Condition: `ex_mem_rd`=1, `ex_rt`≠0, and (`id_uses_rs` and `id_rs`=`ex_rt`) or (`id_uses_rt` and `id_rt`=`ex_rt`).
  - Response: `pc_enable`=1, `IF_ID_enable`=1, `ctrl_bubble`=1; `ID_EX`, `EX_MEM` and `MEM_WB` advance.
  - The hazard self-clears next cycle. No state change.
  - Load-use is ignored in FLUSH, because the ID instruction is being discarded.
- **stall_count:** +1 per cycle with `pc_enable`=1, saturating at 2^32-1.

## Timing
- All outputs are combinational from the current state and inputs; the state is registered.
- **During `rst`=1:**
  - All enables = 1, `ctrl_bubble`=1, `IF_ID_flush`=1.
  - `mem_err`=0, `stall_count`=0.
  - State RUN; `br_pend`, `fcnt` and `wcnt` cleared.
- **After reset:** first posedge with `rst`=0 runs normal RUN behaviour.
- **Reset mid-stall or mid-flush:** same reset behaviour; nothing pending survives.
- **Latencies:**
  - Load-use costs exactly 1 cycle.
  - A taken branch costs `BRANCH_PENALTY` cycles.
  - A memory wait costs (cycles until `mem_ready`) cycles.
- **Simultaneous events:**
  - Memory wait + branch: the branch is deferred via `br_pend`.
  - Branch + load-use: the branch wins and no PC stall occurs.
- `wcnt` clears on MEM_WAIT exit.

## Structure
- Shared package `pipe_pkg`: state enum (RUN, MEM_WAIT, FLUSH), `REG_ZERO` = 5'd0, and the `ADVANCE`=1'b0 / `HOLD`=1'b1 enable constants for reuse by the stage registers.
- One natural sub-module, `load_use_detect`: combinational comparator producing `lu_hazard`.
- The FSM and counters stay in `hazard_ctrl`.

## Test plan
- **Load-use:** `ex_mem_rd`=1, `ex_rt`=8, `id_rs`=8, `id_uses_rs`=1 → one cycle of `pc_enable`=1, `IF_ID_enable`=1, `ctrl_bubble`=1, `ID_EX_enable`=0; `stall_count` goes 0→1. Repeat with `ex_rt`=0 → no stall.
- **Branch:** `branch_taken` pulse, `BRANCH_PENALTY`=2 → `IF_ID_flush`=1 for exactly 2 cycles; `pc_enable` stays 0.
- **Memory wait:** `mem_req`=1, `mem_ready`=0 for 3 cycles then 1 → all enables = 1 for 3 cycles and 0 on the 4th; `stall_count`=3.
- **Branch during wait:** `branch_taken` in wait cycle 2 → no flush during the wait; `IF_ID_flush`=1 for 2 cycles immediately after release.
- **Timeout:** `MEM_TIMEOUT`=4 and `mem_ready` held at 0 → `mem_err`=1 after 4 cycles and the pipe releases; `mem_err` stays 1 until `rst`.
- **Reset mid-FLUSH:** `rst` asserted asynchronously mid-FLUSH → all enables = 1 immediately; after release no residual flush, and `stall_count`=0.
